// File: rtl/if_id_fetch_stage.sv
// Instruction-fetch stage with IF/ID pipeline register and a one-entry skid buffer.
// Honours load-use stalls and EX-stage redirects, discarding a response that is still in flight.
module if_id_fetch_stage #(
   parameter int unsigned     XLEN     = 32,
   parameter logic [XLEN-1:0] RESET_PC = '0,
   parameter int unsigned     PC_STEP  = 4
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            PCWrite,
   input  logic            Reg_IF_ID_Data,
   input  logic            branch_taken,
   input  logic [XLEN-1:0] branch_target,
   output logic            imem_req,
   output logic [XLEN-1:0] imem_addr,
   input  logic [31:0]     imem_rdata,
   input  logic            imem_valid,
   output logic [XLEN-1:0] if_id_pc,
   output logic [31:0]     if_id_instr,
   output logic            if_id_valid
);

   localparam logic [31:0] NOP = 32'h0000_0013;

   typedef enum logic [1:0] {IDLE, FETCH, HOLD, DISCARD} state_t;

   state_t          state_q, state_d;
   logic [XLEN-1:0] pc_q, pc_d, pc_inc;
   logic [XLEN-1:0] if_id_pc_q, if_id_pc_d;
   logic [31:0]     if_id_instr_q, if_id_instr_d;
   logic            if_id_valid_q, if_id_valid_d;
   logic [XLEN-1:0] skid_pc_q, skid_pc_d;
   logic [31:0]     skid_instr_q, skid_instr_d;
   logic            advance, load_fetch, load_skid, to_skid;

   assign advance    = PCWrite & Reg_IF_ID_Data;
   assign pc_inc     = pc_q + XLEN'(PC_STEP);
   assign load_fetch = (state_q == FETCH) && imem_valid && advance;
   assign load_skid  = (state_q == HOLD) && advance;
   assign to_skid    = (state_q == FETCH) && imem_valid && !advance;

   always_ff @(posedge clk) begin
      if (!rst_n) state_q <= IDLE;
      else        state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         IDLE:    state_d = FETCH;
         FETCH: begin
            if (branch_taken)  state_d = imem_valid ? FETCH : DISCARD;
            else if (to_skid)  state_d = HOLD;
         end
         HOLD:    if (branch_taken || advance) state_d = FETCH;
         // the abandoned response retires DISCARD even if a new redirect lands with it
         DISCARD: if (imem_valid) state_d = FETCH;
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      imem_req  = (state_q == FETCH);
      imem_addr = pc_q;
   end

   always_comb begin
      pc_d          = pc_q;
      if_id_pc_d    = if_id_pc_q;
      if_id_instr_d = if_id_instr_q;
      if_id_valid_d = if_id_valid_q;
      skid_pc_d     = skid_pc_q;
      skid_instr_d  = skid_instr_q;
      if (branch_taken) begin
         pc_d          = branch_target;
         if_id_valid_d = 1'b0;
         skid_pc_d     = '0;
         skid_instr_d  = '0;
      end else begin
         if (load_fetch) begin
            if_id_pc_d    = pc_q;
            if_id_instr_d = imem_rdata;
            if_id_valid_d = 1'b1;
            pc_d          = pc_inc;
         end else if (load_skid) begin
            if_id_pc_d    = skid_pc_q;
            if_id_instr_d = skid_instr_q;
            if_id_valid_d = 1'b1;
            pc_d          = pc_inc;
            skid_pc_d     = '0;
            skid_instr_d  = '0;
         end else if (Reg_IF_ID_Data) begin
            if_id_valid_d = 1'b0;
         end
         if (to_skid) begin
            skid_pc_d    = pc_q;
            skid_instr_d = imem_rdata;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         pc_q          <= RESET_PC;
         if_id_pc_q    <= '0;
         if_id_instr_q <= NOP;
         if_id_valid_q <= 1'b0;
         skid_pc_q     <= '0;
         skid_instr_q  <= '0;
      end else begin
         pc_q          <= pc_d;
         if_id_pc_q    <= if_id_pc_d;
         if_id_instr_q <= if_id_instr_d;
         if_id_valid_q <= if_id_valid_d;
         skid_pc_q     <= skid_pc_d;
         skid_instr_q  <= skid_instr_d;
      end
   end

   assign if_id_pc    = if_id_pc_q;
   assign if_id_instr = if_id_instr_q;
   assign if_id_valid = if_id_valid_q;

endmodule

// File: tb/tb_if_id_fetch_stage.sv
// Randomized scoreboard bench for if_id_fetch_stage: the expected IF/ID stream is the
// sequential program order from the last reset or redirect, with a variable-latency memory.
module tb_if_id_fetch_stage;

   localparam logic [31:0] NOP = 32'h0000_0013;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        PCWrite = 1'b0;
   logic        Reg_IF_ID_Data = 1'b0;
   logic        branch_taken = 1'b0;
   logic [31:0] branch_target = '0;
   logic        imem_req;
   logic [31:0] imem_addr;
   logic [31:0] imem_rdata = '0;
   logic        imem_valid = 1'b0;
   logic [31:0] if_id_pc;
   logic [31:0] if_id_instr;
   logic        if_id_valid;

   typedef struct packed {
      logic [31:0] pc;
      logic [31:0] instr;
   } exp_t;

   exp_t        exp_q[$];
   exp_t        e;
   logic [31:0] next_push_pc = '0;
   int unsigned n_checks = 0;
   int unsigned n_fail = 0;
   int unsigned n_deliv = 0;
   bit          done = 1'b0;

   // memory model state
   bit          busy = 1'b0;
   int unsigned cnt = 0;
   logic [31:0] raddr = '0;

   // monitor history: inputs as sampled at the previous edge, and IF/ID as then observed
   logic        rst_last = 1'b0, reg_last = 1'b0, br_last = 1'b0, v_last = 1'b0;
   logic [31:0] pc_last = '0, instr_last = '0;

   always #5 clk = ~clk;

   if_id_fetch_stage #(.XLEN(32), .RESET_PC(32'h0000_0000), .PC_STEP(4)) dut (
      .clk(clk), .rst_n(rst_n), .PCWrite(PCWrite), .Reg_IF_ID_Data(Reg_IF_ID_Data),
      .branch_taken(branch_taken), .branch_target(branch_target),
      .imem_req(imem_req), .imem_addr(imem_addr), .imem_rdata(imem_rdata),
      .imem_valid(imem_valid), .if_id_pc(if_id_pc), .if_id_instr(if_id_instr),
      .if_id_valid(if_id_valid)
   );

   function automatic logic [31:0] instr_of(input logic [31:0] a);
      return a ^ 32'h1357_9BDF;
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] want);
      n_checks++;
      if (act !== want) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, want, $time);
      end
   endtask

   // One clock cycle of stimulus, including the reference-stream bookkeeping and memory.
   task automatic cycle(input bit directed, input bit do_rst);
      logic [31:0] r;
      @(posedge clk);
      #1;
      if (!rst_n) begin
         exp_q.delete();
         next_push_pc = 32'h0000_0000;
      end else if (branch_taken) begin
         exp_q.delete();
         next_push_pc = branch_target;
      end
      while (exp_q.size() < 4) begin
         exp_q.push_back('{pc: next_push_pc, instr: instr_of(next_push_pc)});
         next_push_pc = next_push_pc + 32'd4;
      end

      rst_n = !do_rst;
      if (directed) begin
         PCWrite        = 1'b1;
         Reg_IF_ID_Data = 1'b1;
         branch_taken   = 1'b0;
      end else begin
         PCWrite        = ($urandom_range(0, 7) != 0);
         Reg_IF_ID_Data = ($urandom_range(0, 7) != 0);
         branch_taken   = rst_n && ($urandom_range(0, 15) == 0);
         r = $urandom;
         if (r[1:0] == 2'b00) branch_target = 32'hFFFF_FFF0 + {28'd0, r[3:2], 2'b00};
         else                 branch_target = {16'd0, r[15:2], 2'b00};
      end

      imem_valid = 1'b0;
      if (!rst_n) begin
         busy = 1'b0;
      end else begin
         if (!busy && imem_req) begin
            busy  = 1'b1;
            raddr = imem_addr;
            cnt   = directed ? 0 : $urandom_range(0, 3);
         end
         if (busy) begin
            if (cnt == 0) begin
               imem_valid = 1'b1;
               imem_rdata = instr_of(raddr);
               busy       = 1'b0;
            end else begin
               cnt--;
            end
         end
      end
   endtask

   always @(negedge clk) begin
      if (!done) begin
         if (!rst_last) begin
            check("rst_req", {31'd0, imem_req}, 32'd0);
            check("rst_valid", {31'd0, if_id_valid}, 32'd0);
            check("rst_pc", if_id_pc, 32'd0);
            check("rst_instr", if_id_instr, NOP);
         end else begin
            if (br_last) begin
               check("flush_valid", {31'd0, if_id_valid}, 32'd0);
            end else if (!reg_last) begin
               check("hold_valid", {31'd0, if_id_valid}, {31'd0, v_last});
               check("hold_pc", if_id_pc, pc_last);
               check("hold_instr", if_id_instr, instr_last);
            end else if (if_id_valid) begin
               if (exp_q.size() == 0) begin
                  check("deliv_underflow", 32'd1, 32'd0);
               end else begin
                  e = exp_q.pop_front();
                  check("deliv_pc", if_id_pc, e.pc);
                  check("deliv_instr", if_id_instr, e.instr);
                  n_deliv++;
               end
            end
            if (imem_req && exp_q.size() != 0) check("req_addr", imem_addr, exp_q[0].pc);
         end
      end
      rst_last   = rst_n;
      reg_last   = Reg_IF_ID_Data;
      br_last    = branch_taken;
      v_last     = if_id_valid;
      pc_last    = if_id_pc;
      instr_last = if_id_instr;
   end

   initial begin
      cycle(1'b1, 1'b1);
      cycle(1'b1, 1'b1);
      for (int i = 0; i < 20; i++) cycle(1'b1, 1'b0);
      check("stream_count_ok", {31'd0, (n_deliv >= 15)}, 32'd1);
      for (int i = 0; i < 3000; i++) begin
         if ($urandom_range(0, 299) == 0) begin
            cycle(1'b0, 1'b1);
            cycle(1'b0, 1'b1);
         end else begin
            cycle(1'b0, 1'b0);
         end
      end
      for (int i = 0; i < 3; i++) cycle(1'b1, 1'b0);
      @(negedge clk);
      check("liveness_ok", {31'd0, (n_deliv > 300)}, 32'd1);
      done = 1'b1;
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
